// File: rtl/is_fu_queue_pkg.sv
// rtl/is_fu_queue_pkg.sv - shared vector types, lmul encodings and micro-op decode
package is_fu_queue_pkg;

    localparam logic [2:0] LMUL_1    = 3'b000;
    localparam logic [2:0] LMUL_2    = 3'b001;
    localparam logic [2:0] LMUL_4    = 3'b010;
    localparam logic [2:0] LMUL_8    = 3'b011;
    localparam logic [2:0] LMUL_RSVD = 3'b100;
    localparam logic [2:0] LMUL_F8   = 3'b101;
    localparam logic [2:0] LMUL_F4   = 3'b110;
    localparam logic [2:0] LMUL_F2   = 3'b111;

    typedef struct packed {
        logic [6:0] opcode;
        logic [4:0] vd;
        logic [4:0] vs1;
        logic [4:0] vs2;
        logic       vm;
        logic [2:0] lmul;
    } dec_req_t;

    // Fractional and reserved groupings occupy a single register, so one micro-op.
    function automatic logic [3:0] lmul_to_nuops(input logic [2:0] lmul);
        case (lmul)
            LMUL_2:  return 4'd2;
            LMUL_4:  return 4'd4;
            LMUL_8:  return 4'd8;
            default: return 4'd1;
        endcase
    endfunction

    function automatic logic [2:0] lmul_last_idx(input logic [2:0] lmul);
        logic [3:0] last;
        last = lmul_to_nuops(lmul) - 4'd1;
        return last[2:0];
    endfunction

endpackage

// File: rtl/is_fu_queue_if.sv
// rtl/is_fu_queue_if.sv - dispatch-side and execution-side handshakes of the FU queue
interface is_fu_queue_if #(
    parameter int IDW = 3
) ();
    import is_fu_queue_pkg::*;

    logic           in_valid;
    logic           in_ready;
    dec_req_t       in_req;
    logic [IDW-1:0] in_id;

    logic           uop_valid;
    logic           uop_ready;
    dec_req_t       uop_req;
    logic [IDW-1:0] uop_id;
    logic [2:0]     uop_idx;
    logic           uop_last;

    modport master (
        output in_valid, in_req, in_id, uop_ready,
        input  in_ready, uop_valid, uop_req, uop_id, uop_idx, uop_last
    );

    modport slave (
        input  in_valid, in_req, in_id, uop_ready,
        output in_ready, uop_valid, uop_req, uop_id, uop_idx, uop_last
    );

endinterface

// File: rtl/is_fifo.sv
// rtl/is_fifo.sv - circular buffer with wrapping pointers and occupancy count
module is_fifo #(
    parameter  int DEPTH = 4,
    parameter  int W     = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  head_data,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [W-1:0]  mem_q [DEPTH];

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wr_ptr_q] <= push_data;
    end

    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;
    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);

endmodule

// File: rtl/is_fu_queue.sv
// rtl/is_fu_queue.sv - FU instruction queue that splits each entry into lmul micro-ops
module is_fu_queue
    import is_fu_queue_pkg::*;
#(
    parameter  int DEPTH = 4,
    parameter  int IDW   = 3,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    is_fu_queue_if.slave  io,
    output logic [CW-1:0] count
);

    localparam int W = $bits(dec_req_t) + IDW;

    logic           fifo_push;
    logic           fifo_pop;
    logic           fifo_full;
    logic           fifo_empty;
    logic [W-1:0]   fifo_head;
    dec_req_t       head_req;
    logic [IDW-1:0] head_id;
    logic           pop_uop;
    logic           last_uop;
    logic [2:0]     uop_cnt_q, uop_cnt_d;

    // Accepting is independent of the execution side, so a full queue waits a cycle after a final pop.
    assign io.in_ready = ~fifo_full & ~flush;
    assign fifo_push   = io.in_valid & io.in_ready;

    is_fifo #(
        .DEPTH (DEPTH),
        .W     (W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .push      (fifo_push),
        .push_data ({io.in_req, io.in_id}),
        .pop       (fifo_pop),
        .head_data (fifo_head),
        .count     (count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign {head_req, head_id} = fifo_head;

    assign last_uop = ~fifo_empty & (uop_cnt_q == lmul_last_idx(head_req.lmul));
    assign pop_uop  = io.uop_valid & io.uop_ready;
    assign fifo_pop = pop_uop & last_uop & ~flush;

    always_comb begin
        uop_cnt_d = uop_cnt_q;
        if (flush) begin
            uop_cnt_d = '0;
        end else if (pop_uop) begin
            uop_cnt_d = last_uop ? 3'd0 : uop_cnt_q + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) uop_cnt_q <= '0;
        else        uop_cnt_q <= uop_cnt_d;
    end

    assign io.uop_valid = ~fifo_empty;
    assign io.uop_req   = head_req;
    assign io.uop_id    = head_id;
    assign io.uop_idx   = uop_cnt_q;
    assign io.uop_last  = last_uop;

endmodule

// File: tb/tb_is_fu_queue.sv
// tb/tb_is_fu_queue.sv - directed and random checks of is_fu_queue against a queue model
module tb_is_fu_queue;
    import is_fu_queue_pkg::*;

    localparam int DEPTH = 4;
    localparam int IDW   = 3;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic [CW-1:0] count;

    is_fu_queue_if #(.IDW(IDW)) bus ();

    is_fu_queue #(.DEPTH(DEPTH), .IDW(IDW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .io    (bus),
        .count (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        dec_req_t       req;
        logic [IDW-1:0] id;
    } ent_t;

    ent_t mq[$];
    int   midx;
    int   vectors;
    int   miscompares;

    function automatic int n_uops(input logic [2:0] lmul);
        return (lmul < 3'd4) ? (1 << lmul) : 1;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit v, input logic [2:0] lmul, input logic [IDW-1:0] id,
                         input bit rdy, input bit fl);
        logic [31:0] rnd;
        dec_req_t    r;
        rnd    = $urandom;
        r      = rnd[$bits(dec_req_t)-1:0];
        r.lmul = lmul;
        bus.in_valid  = v;
        bus.in_req    = r;
        bus.in_id     = id;
        bus.uop_ready = rdy;
        flush         = fl;
    endtask

    task automatic check_outputs();
        bit valid;
        valid = (mq.size() != 0);
        check("count", 64'(count), 64'(mq.size()));
        check("in_ready", 64'(bus.in_ready), 64'((mq.size() < DEPTH) && !flush));
        check("uop_valid", 64'(bus.uop_valid), 64'(valid));
        if (valid) begin
            check("uop_idx", 64'(bus.uop_idx), 64'(midx));
            check("uop_last", 64'(bus.uop_last), 64'(midx == n_uops(mq[0].req.lmul) - 1));
            check("uop_id", 64'(bus.uop_id), 64'(mq[0].id));
            check("uop_req", 64'(bus.uop_req), 64'(mq[0].req));
        end else begin
            check("uop_idx_empty", 64'(bus.uop_idx), 64'd0);
            check("uop_last_empty", 64'(bus.uop_last), 64'd0);
        end
    endtask

    task automatic step();
        bit   valid;
        bit   last;
        bit   acc;
        ent_t e;
        #1;
        check_outputs();
        valid = (mq.size() != 0);
        last  = valid && (midx == n_uops(mq[0].req.lmul) - 1);
        acc   = (mq.size() < DEPTH) && !flush;
        if (flush) begin
            mq.delete();
            midx = 0;
        end else begin
            if (valid && bus.uop_ready) begin
                if (last) begin
                    void'(mq.pop_front());
                    midx = 0;
                end else begin
                    midx++;
                end
            end
            if (bus.in_valid && acc) begin
                e.req = bus.in_req;
                e.id  = bus.in_id;
                mq.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        midx        = 0;
        drive(0, 3'd0, '0, 0, 0);
        #2;
        check_outputs();
        @(posedge clk);
        #1 rst_n = 1'b1;

        // single-uop instruction, id 5
        drive(1, 3'd0, 3'd5, 1, 0); step();
        drive(0, 3'd0, '0, 1, 0);   step(); step();

        // lmul=8 sequence
        drive(1, 3'd3, 3'd2, 1, 0); step();
        drive(0, 3'd0, '0, 1, 0);   repeat (9) step();

        // fill to full, then drain with wrap
        for (int i = 0; i < 4; i++) begin
            drive(1, 3'd0, IDW'(i), 0, 0); step();
        end
        drive(0, 3'd0, '0, 0, 0); step();
        drive(0, 3'd0, '0, 1, 0); step(); step();
        for (int i = 0; i < 10; i++) begin
            drive(1, 3'd0, IDW'(i), 1, 0); step();
        end
        drive(0, 3'd0, '0, 1, 0); repeat (6) step();

        // stall mid-instruction at idx 1
        drive(1, 3'd2, 3'd3, 1, 0); step();
        drive(0, 3'd0, '0, 1, 0);   step();
        drive(0, 3'd0, '0, 0, 0);   repeat (5) step();
        drive(0, 3'd0, '0, 1, 0);   repeat (4) step();

        // flush with a concurrent push while head at idx 2
        drive(1, 3'd2, 3'd1, 0, 0); step();
        drive(1, 3'd0, 3'd2, 0, 0); step();
        drive(1, 3'd1, 3'd3, 0, 0); step();
        drive(0, 3'd0, '0, 1, 0);   step(); step();
        drive(1, 3'd0, 3'd7, 1, 1); step();
        drive(0, 3'd0, '0, 1, 0);   step(); step();

        // async reset mid-instruction at idx 4
        drive(1, 3'd3, 3'd4, 1, 0); step();
        drive(0, 3'd0, '0, 1, 0);   repeat (4) step();
        check("pre_rst_idx", 64'(bus.uop_idx), 64'd4);
        rst_n = 1'b0;
        #1;
        mq.delete();
        midx = 0;
        check("rst_uop_valid", 64'(bus.uop_valid), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_uop_idx", 64'(bus.uop_idx), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) step();

        // random traffic
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 9) < 6, 3'($urandom), IDW'($urandom),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 29) == 0);
            step();
        end
        drive(0, 3'd0, '0, 1, 0);
        repeat (40) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
